dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder: the memory-side end of the core's load/store data port.
- Accepts one request at a time from the execution unit's load/store path. Requests carry a byte address, write enable, access size and right-aligned store data.
- Applies byte-lane steering and byte enables to an internal word array, inserts programmable wait states, and returns a one-cycle response with the addressed read word.
- Sits between the core execution unit and on-chip data SRAM. Sign/zero extension of loads remains in the core.

Parameters:
- MEM_ADDR_WIDTH, 10, byte-address width; array depth = 2^(MEM_ADDR_WIDTH-2) words.
- DATA_WIDTH, 32, data word width; fixed at 32 (4 byte lanes).
- WAIT_CYCLES, 1, wait states inserted between accept and response; legal range 0..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_i  input  1  request valid.
- gnt_o  output  1  request accepted on the edge where req_i && gnt_o.
- we_i  input  1  1 = store, 0 = load.
- size_i  input  2  00 byte, 01 halfword, 10 word, 11 invalid.
- addr_i  input  MEM_ADDR_WIDTH  byte address.
- wdata_i  input  DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0]).
- rvalid_o  output  1  one-cycle response pulse.
- rdata_o  output  DATA_WIDTH  full aligned word at addr[MSB:2]; valid only with rvalid_o on a load.
- err_o  output  1  access error, qualified by rvalid_o.

Behaviour:
- Reset values:
  - gnt_o=1 (combinational from IDLE), rvalid_o=0, rdata_o=0, err_o=0, state=IDLE, wait counter=0.
  - Array contents are not reset and are retained across reset.
- FSM states IDLE, WAIT, RESP.
  - gnt_o=1 in IDLE and RESP; gnt_o=0 in WAIT.
  - IDLE/RESP with accept: latch addr, we, size, wdata. Next state is WAIT (counter=WAIT_CYCLES-1) if WAIT_CYCLES>0, else RESP.
  - IDLE/RESP without accept: next state IDLE.
  - WAIT: decrement counter; at 0, next state RESP.
  - RESP: rvalid_o=1 for exactly this cycle.
- Latency: rvalid_o asserts WAIT_CYCLES+1 cycles after the accept edge. Back-to-back accept in RESP gives one request per WAIT_CYCLES+1 cycles.
- Inputs are sampled only at accept; changes afterwards are ignored.
- Store commit and read capture:
  - A store writes the array on the edge entering RESP.
  - A load captures rdata_o on the same edge; rdata_o holds until the next load response.
- Byte lanes, from addr[1:0]:
  - byte: BE=1<<addr[1:0]; wdata[7:0] replicated to all lanes.
  - half: BE=0011 or 1100 per addr[1]; wdata[15:0] replicated to both halves.
  - word: BE=1111.
  - Only enabled lanes are written.
- Load after store to the same word, issued back-to-back, returns the updated data.
- Stores respond with rvalid_o=1, err_o=0, rdata_o unchanged.
- Reset mid-operation returns to IDLE; a pending store is discarded and no write occurs.
- Address wrap: word index uses addr[MEM_ADDR_WIDTH-1:2] only; no out-of-range case exists.

Optional Feature:
- Macro DMEM_MISALIGN_TRAP_EN.
- Defined:
  - These accesses are errors: half with addr[0]=1, word with addr[1:0]!=00, or size_i=11.
  - An error access completes with normal latency and asserts err_o=1 with rvalid_o.
  - No array write occurs, and rdata_o=0 for error loads.
- Undefined:
  - err_o is tied 0.
  - Low address bits are forced aligned (half ignores addr[0], word ignores addr[1:0]).
  - size_i=11 is treated as word.

Test Plan:
- WAIT_CYCLES=1: store word 0xDEADBEEF @0x010, then load @0x010 -> rvalid_o 2 cycles after each accept; rdata_o=0xDEADBEEF, err_o=0.
- Store byte 0xA5 @0x013 onto word 0x11223344 at 0x010, then load word @0x010 -> rdata_o=0xA5223344. Store half 0x7788 @0x012 -> next load 0x77883344.
- WAIT_CYCLES=0, req_i held high for 4 loads -> gnt_o stays 1; one rvalid_o per cycle starting 1 cycle after the first accept.
- Assert rst during WAIT of a store of 0xFFFFFFFF @0x020 (prior 0x0) -> rvalid_o=0 immediately; subsequent load @0x020 returns 0x00000000.
- DMEM_MISALIGN_TRAP_EN defined: word store 0x12345678 @0x021 -> rvalid_o=1, err_o=1; load @0x020 returns the prior value. Undefined: same store writes @0x020, err_o=0.
- gnt_o=0 during WAIT with req_i=1 and changing addr_i -> no extra response; the latched address is honoured.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: memory-side end of the core load/store data port.
// Accepts one request at a time, inserts WAIT_CYCLES wait states, steers
// store bytes into an internal word array, and returns a one-cycle response
// carrying the full aligned read word (extension of loads stays in the core).
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   : misaligned half/word and size 11 complete with err_o=1,
//               no array write, rdata_o=0 for error loads.
//   undefined : err_o is always 0, low address bits are forced aligned,
//               size 11 is treated as a word access.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_i / gnt_o     request handshake; accept when req_i && gnt_o
//   we_i, size_i      store enable, access size (00 B, 01 H, 10 W, 11 invalid)
//   addr_i, wdata_i   byte address, right-aligned store data
//   rvalid_o          one-cycle response pulse
//   rdata_o           aligned read word (held until the next load response)
//   err_o             access error, qualified by rvalid_o
module dmem_responder #(
  parameter int unsigned MEM_ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned WAIT_CYCLES    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic                      we_i,
  input  logic [1:0]                size_i,
  input  logic [MEM_ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  output logic                      rvalid_o,
  output logic [DATA_WIDTH-1:0]     rdata_o,
  output logic                      err_o
);

  localparam int unsigned IDX_W = MEM_ADDR_WIDTH - 2;
  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                    state;
  logic [CNT_W-1:0]          wait_cnt;

  logic                      lat_we;
  logic [1:0]                lat_size;
  logic [MEM_ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0]     lat_wdata;

  logic [DATA_WIDTH-1:0]     mem [DEPTH];

  logic                      accept;
  logic                      commit;
  logic                      cur_we;
  logic [1:0]                cur_size;
  logic [MEM_ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0]     cur_wdata;
  logic [IDX_W-1:0]          cur_idx;
  logic [NB-1:0]             lane_be;
  logic [DATA_WIDTH-1:0]     lane_wdata;
  logic                      acc_err;

  // Grant is open whenever we are not counting wait states.
  assign gnt_o  = (state != S_WAIT);
  assign accept = req_i && gnt_o;

  // With zero wait states the access commits on the accept edge itself, so
  // the live inputs are used; otherwise the latched request is used.
  always_comb begin
    if (WAIT_CYCLES == 0) begin
      cur_we    = we_i;
      cur_size  = size_i;
      cur_addr  = addr_i;
      cur_wdata = wdata_i;
      commit    = !rst && accept;
    end else begin
      cur_we    = lat_we;
      cur_size  = lat_size;
      cur_addr  = lat_addr;
      cur_wdata = lat_wdata;
      commit    = !rst && (state == S_WAIT) && (wait_cnt == '0);
    end
  end

  assign cur_idx = cur_addr[MEM_ADDR_WIDTH-1:2];

  // Byte-lane steering and error classification.
  always_comb begin
    lane_be    = '0;
    lane_wdata = cur_wdata;
    acc_err    = 1'b0;
    case (cur_size)
      2'b00: begin
        lane_be    = NB'(4'b0001 << cur_addr[1:0]);
        lane_wdata = {NB{cur_wdata[7:0]}};
      end
      2'b01: begin
        lane_be    = cur_addr[1] ? NB'(4'b1100) : NB'(4'b0011);
        lane_wdata = {(NB/2){cur_wdata[15:0]}};
`ifdef DMEM_MISALIGN_TRAP_EN
        acc_err    = cur_addr[0];
`endif
      end
      default: begin
        lane_be    = '1;
`ifdef DMEM_MISALIGN_TRAP_EN
        acc_err    = (cur_addr[1:0] != 2'b00) || (cur_size == 2'b11);
`endif
      end
    endcase
  end

  // Array write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (commit && cur_we && !acc_err) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (lane_be[b]) begin
          mem[cur_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
        end
      end
    end
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      lat_we    <= 1'b0;
      lat_size  <= 2'b00;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rvalid_o  <= 1'b0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
    end else begin
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;

      case (state)
        S_IDLE, S_RESP: begin
          if (accept) begin
            lat_we    <= we_i;
            lat_size  <= size_i;
            lat_addr  <= addr_i;
            lat_wdata <= wdata_i;
            if (WAIT_CYCLES > 0) begin
              state    <= S_WAIT;
              wait_cnt <= CNT_W'(WAIT_CYCLES - 1);
            end else begin
              state    <= S_RESP;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            state <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase

      // Response data is captured on the edge entering RESP.
      if (commit) begin
        rvalid_o <= 1'b1;
        err_o    <= acc_err;
        if (!cur_we) begin
          rdata_o <= acc_err ? '0 : mem[cur_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk;
  logic        rst;

  // Instance with one wait state.
  logic        req1, we1, gnt1, rvalid1, err1;
  logic [1:0]  size1;
  logic [9:0]  addr1;
  logic [31:0] wdata1, rdata1;

  // Instance with zero wait states.
  logic        req0, we0, gnt0, rvalid0, err0;
  logic [1:0]  size0;
  logic [9:0]  addr0;
  logic [31:0] wdata0, rdata0;

  int checks;
  int errors;

  dmem_responder #(.MEM_ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req_i(req1), .gnt_o(gnt1), .we_i(we1),
    .size_i(size1), .addr_i(addr1), .wdata_i(wdata1),
    .rvalid_o(rvalid1), .rdata_o(rdata1), .err_o(err1)
  );

  dmem_responder #(.MEM_ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_i(req0), .gnt_o(gnt0), .we_i(we0),
    .size_i(size0), .addr_i(addr0), .wdata_i(wdata0),
    .rvalid_o(rvalid0), .rdata_o(rdata0), .err_o(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One access on the one-wait-state instance; returns while in RESP.
  task automatic acc1(input string tag, input logic we, input logic [1:0] size,
                      input logic [9:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
    req1 = 1'b1; we1 = we; size1 = size; addr1 = addr; wdata1 = wdata;
    @(posedge clk); #1;
    req1 = 1'b0;
    check({tag, "_gnt_wait"}, 32'(gnt1), 32'd0);
    check({tag, "_rvalid_wait"}, 32'(rvalid1), 32'd0);
    @(posedge clk); #1;
    check({tag, "_rvalid"}, 32'(rvalid1), 32'd1);
    check({tag, "_err"}, 32'(err1), 32'(exp_err));
    check({tag, "_rdata"}, rdata1, exp_rdata);
  endtask

  initial begin
    logic [31:0] exp_mis_load;
    logic        exp_mis_err;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    req1 = 1'b0; we1 = 1'b0; size1 = 2'b00; addr1 = '0; wdata1 = '0;
    req0 = 1'b0; we0 = 1'b0; size0 = 2'b00; addr0 = '0; wdata0 = '0;

    @(posedge clk); #1;
    check("rst_gnt", 32'(gnt1), 32'd1);
    check("rst_rvalid", 32'(rvalid1), 32'd0);
    check("rst_rdata", rdata1, 32'd0);
    check("rst_err", 32'(err1), 32'd0);
    check("rst_gnt0", 32'(gnt0), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Word store then load.
    acc1("st_deadbeef", 1'b1, 2'b10, 10'h010, 32'hDEADBEEF, 32'h0, 1'b0);
    acc1("ld_deadbeef", 1'b0, 2'b10, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0);

    // Byte and halfword merges.
    acc1("st_base", 1'b1, 2'b10, 10'h010, 32'h11223344, 32'hDEADBEEF, 1'b0);
    acc1("st_byte3", 1'b1, 2'b00, 10'h013, 32'h000000A5, 32'hDEADBEEF, 1'b0);
    acc1("ld_byte3", 1'b0, 2'b10, 10'h010, 32'h0, 32'hA5223344, 1'b0);
    acc1("st_half1", 1'b1, 2'b01, 10'h012, 32'h00007788, 32'hA5223344, 1'b0);
    acc1("ld_half1", 1'b0, 2'b10, 10'h010, 32'h0, 32'h77883344, 1'b0);
    acc1("st_byte1", 1'b1, 2'b00, 10'h011, 32'hFFFFFF5A, 32'h77883344, 1'b0);
    acc1("ld_byte1", 1'b0, 2'b10, 10'h010, 32'h0, 32'h77885A44, 1'b0);

    // Misaligned word store and invalid-size load.
`ifdef DMEM_MISALIGN_TRAP_EN
    exp_mis_err  = 1'b1;
    exp_mis_load = 32'h00000000;
`else
    exp_mis_err  = 1'b0;
    exp_mis_load = 32'h12345678;
`endif
    acc1("st_zero20", 1'b1, 2'b10, 10'h020, 32'h0, 32'h77885A44, 1'b0);
    acc1("st_mis21", 1'b1, 2'b10, 10'h021, 32'h12345678, 32'h77885A44, exp_mis_err);
    acc1("ld_mis20", 1'b0, 2'b10, 10'h020, 32'h0, exp_mis_load, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
    acc1("ld_size11", 1'b0, 2'b11, 10'h010, 32'h0, 32'h0, 1'b1);
`else
    acc1("ld_size11", 1'b0, 2'b11, 10'h010, 32'h0, 32'h77885A44, 1'b0);
`endif
    @(posedge clk); #1;

    // Request held with changing address during WAIT is ignored.
    req1 = 1'b1; we1 = 1'b0; size1 = 2'b10; addr1 = 10'h010;
    @(posedge clk); #1;
    check("hold_gnt_wait", 32'(gnt1), 32'd0);
    addr1 = 10'h030;
    @(posedge clk); #1;
    req1 = 1'b0;
    check("hold_rvalid", 32'(rvalid1), 32'd1);
    check("hold_rdata", rdata1, 32'h77885A44);
    @(posedge clk); #1;
    check("hold_no_extra", 32'(rvalid1), 32'd0);
    check("hold_gnt_idle", 32'(gnt1), 32'd1);

    // Reset during WAIT discards the pending store.
    acc1("st_pre20", 1'b1, 2'b10, 10'h020, 32'h0, 32'h77885A44, 1'b0);
    req1 = 1'b1; we1 = 1'b1; size1 = 2'b10; addr1 = 10'h020; wdata1 = 32'hFFFFFFFF;
    @(posedge clk); #1;
    req1 = 1'b0;
    check("rstmid_gnt_wait", 32'(gnt1), 32'd0);
    rst = 1'b1;
    #1;
    check("rstmid_rvalid", 32'(rvalid1), 32'd0);
    check("rstmid_gnt", 32'(gnt1), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    acc1("ld_after_rst", 1'b0, 2'b10, 10'h020, 32'h0, 32'h00000000, 1'b0);

    // Back-to-back store then load to the same word.
    acc1("b2b_st", 1'b1, 2'b10, 10'h040, 32'hCAFEF00D, 32'h00000000, 1'b0);
    acc1("b2b_ld", 1'b0, 2'b10, 10'h040, 32'h0, 32'hCAFEF00D, 1'b0);
    @(posedge clk); #1;

    // Zero wait states: four stores then four loads with req held high.
    check("z_rvalid_idle", 32'(rvalid0), 32'd0);
    req0 = 1'b1; we0 = 1'b1; size0 = 2'b10; addr0 = 10'h000; wdata0 = 32'h100;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("z_st%0d_gnt", i), 32'(gnt0), 32'd1);
      check($sformatf("z_st%0d_rvalid", i), 32'(rvalid0), 32'd1);
      check($sformatf("z_st%0d_rdata", i), rdata0, 32'd0);
      if (i < 3) begin
        addr0  = 10'(4 * (i + 1));
        wdata0 = 32'h100 + 32'(i + 1);
      end else begin
        we0   = 1'b0;
        addr0 = 10'h000;
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("z_ld%0d_gnt", i), 32'(gnt0), 32'd1);
      check($sformatf("z_ld%0d_rvalid", i), 32'(rvalid0), 32'd1);
      check($sformatf("z_ld%0d_err", i), 32'(err0), 32'd0);
      check($sformatf("z_ld%0d_rdata", i), rdata0, 32'h100 + 32'(i));
      if (i < 3) addr0 = 10'(4 * (i + 1));
      else       req0  = 1'b0;
    end
    @(posedge clk); #1;
    check("z_rvalid_end", 32'(rvalid0), 32'd0);
    check("z_rdata_hold", rdata0, 32'h103);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
